// File: rtl/mem_pkg.sv
// Shared FSM state type and sizing constants for the LSU memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MEM_XLEN = 64;
  localparam int CNT_W    = 4;

  function automatic int strb_w(input int xlen);
    return xlen / 8;
  endfunction

  localparam int WSTRB_W = strb_w(MEM_XLEN);

endpackage

// File: rtl/lsu_mem_slave_if.sv
// Load/store request/response channel between the core (master) and memory (slave).
interface lsu_mem_slave_if import mem_pkg::*; #(
  parameter int XLEN = MEM_XLEN
);
  localparam int SW = strb_w(XLEN);

  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_wen_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic [SW-1:0]   req_wstrb_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;

  modport slave (
    input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/mem_sram_bank.sv
// Word store split into per-byte lanes: byte-masked synchronous write, combinational read.
module mem_sram_bank import mem_pkg::*; #(
  parameter int XLEN       = MEM_XLEN,
  parameter int DEPTH_LOG2 = 10,
  parameter int STRB_W     = WSTRB_W
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] wr_idx_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  output logic [XLEN-1:0]       rdata_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // One array per byte lane so each strobe bit owns its own write port.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we_i && wstrb_i[gi]) begin
          lane_mem[wr_idx_i] <= wdata_i[gi*8 +: 8];
        end
      end

      assign rdata_o[gi*8 +: 8] = lane_mem[rd_idx_i];
    end
  endgenerate
endmodule

// File: rtl/lsu_mem_slave.sv
// Single-outstanding memory responder: fixed-latency load/store with range check
// and a response held until the core accepts it.
module lsu_mem_slave import mem_pkg::*; #(
  parameter int              XLEN       = 64,
  parameter int              DEPTH_LOG2 = 10,
  parameter int              LATENCY    = 2,
  parameter logic [XLEN-1:0] BASE_ADDR  = XLEN'(64'h8000_0000)
) (
  input logic              clk,
  input logic              rst_n,
  lsu_mem_slave_if.slave   bus
);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wen_q, wen_d;
  logic                    in_range_q, in_range_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]         rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [XLEN-1:0]         offset;
  logic                    req_in_range;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    accept;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [XLEN-1:0]         bank_rdata;
  logic                    enter_resp;
  logic                    unused_addr_lo;

  // Addresses below BASE wrap to a huge offset, so one upper-bits test covers both bounds.
  assign offset         = bus.req_addr_i - BASE_ADDR;
  assign req_in_range   = ~|offset[XLEN-1:DEPTH_LOG2+3];
  assign req_idx        = offset[DEPTH_LOG2+2:3];
  assign unused_addr_lo = ^offset[2:0];

  assign accept = bus.req_valid_i && (state_q == IDLE);
  assign mem_we = accept && bus.req_wen_i && req_in_range;
  // With LATENCY==1 the read happens on the accept edge, before idx_q is loaded.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;

  mem_sram_bank #(
    .XLEN       (XLEN),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .STRB_W     (strb_w(XLEN))
  ) u_bank (
    .clk      (clk),
    .we_i     (mem_we),
    .wr_idx_i (req_idx),
    .wdata_i  (bus.req_wdata_i),
    .wstrb_i  (bus.req_wstrb_i),
    .rd_idx_i (rd_idx),
    .rdata_o  (bank_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    in_range_d  = in_range_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    enter_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wen_d      = bus.req_wen_i;
          in_range_d = req_in_range;
          idx_d      = req_idx;
          cnt_d      = LAT_M1;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          cnt_d      = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      err_d       = !in_range_d;
      rdata_d     = (!wen_d && in_range_d) ? bank_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      in_range_q  <= 1'b0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      in_range_q  <= in_range_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_lsu_mem_slave.sv
// Directed bench: three responders (LATENCY 2, 1, 15) driven from shared tasks.
module tb_lsu_mem_slave;
  localparam int          XLEN = 64;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  req_valid, req_wen, rsp_ready;
  logic [63:0] req_addr  [3];
  logic [63:0] req_wdata [3];
  logic [7:0]  req_wstrb [3];
  logic [2:0]  req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata [3];

  int n_checks = 0;
  int n_errors = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;
      lsu_mem_slave_if #(.XLEN(XLEN)) bus ();
      assign bus.req_valid_i = req_valid[gi];
      assign bus.req_wen_i   = req_wen[gi];
      assign bus.req_addr_i  = req_addr[gi];
      assign bus.req_wdata_i = req_wdata[gi];
      assign bus.req_wstrb_i = req_wstrb[gi];
      assign bus.rsp_ready_i = rsp_ready[gi];
      assign req_ready[gi]   = bus.req_ready_o;
      assign rsp_valid[gi]   = bus.rsp_valid_o;
      assign rsp_rdata[gi]   = bus.rsp_rdata_o;
      assign rsp_err[gi]     = bus.rsp_err_o;

      lsu_mem_slave #(
        .XLEN       (XLEN),
        .DEPTH_LOG2 (10),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n[gi]),
        .bus   (bus)
      );
    end
  endgenerate

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 15;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present a request and return #1 after the edge that accepted it.
  task automatic issue(input int d, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] strb);
    int waited;
    waited       = 0;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wstrb[d] = strb;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_ready[d]) check("accept_timeout", 64'(req_ready[d]), 64'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  // lat counts accept edge as 1; equals LATENCY when valid is seen at edge T+LATENCY.
  task automatic wait_valid(input int d, output int lat);
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_req(input int d, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] strb,
                        output logic [63:0] rdata, output logic err, output int lat);
    rsp_ready[d] = 1'b1;
    issue(d, wen, addr, wdata, strb);
    wait_valid(d, lat);
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    @(posedge clk); #1;
    check("hs_clear", 64'(rsp_valid[d]), 64'd0);
  endtask

  task automatic load_chk(input int d, input logic [63:0] addr, input logic [63:0] exp,
                          input logic exp_err, input string tag);
    logic [63:0] rd;
    logic        er;
    int          lat;
    do_req(d, 1'b0, addr, 64'd0, 8'h00, rd, er, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(lat_of(d)));
  endtask

  task automatic store_chk(input int d, input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic exp_err, input string tag);
    logic [63:0] rd;
    logic        er;
    int          lat;
    do_req(d, 1'b1, addr, data, strb, rd, er, lat);
    check({tag, "_data"}, rd, 64'd0);
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(lat_of(d)));
  endtask

  initial begin
    int          lat;
    int          bad;
    logic [63:0] v;
    logic [63:0] w;

    rst_n     = '0;
    req_valid = '0;
    req_wen   = '0;
    rsp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_wstrb[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = '1;

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("idle_ready", 64'(req_ready[0]), 64'd1);
      check("idle_valid", 64'(rsp_valid[0]), 64'd0);
      check("idle_rdata", rsp_rdata[0], 64'd0);
      check("idle_err", 64'(rsp_err[0]), 64'd0);
    end
    for (int d = 1; d < 3; d++) begin
      check($sformatf("idle%0d_ready", d), 64'(req_ready[d]), 64'd1);
      check($sformatf("idle%0d_valid", d), 64'(rsp_valid[d]), 64'd0);
    end

    store_chk(0, BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, "st_full");
    load_chk (0, BASE + 64'h10, 64'h1122_3344_5566_7788, 1'b0, "ld_full");
    store_chk(0, BASE + 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0, "st_part");
    load_chk (0, BASE + 64'h10, 64'h1122_3344_AAAA_AAAA, 1'b0, "ld_part");
    store_chk(0, BASE + 64'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b0, "st_nostrb");
    load_chk (0, BASE + 64'h10, 64'h1122_3344_AAAA_AAAA, 1'b0, "ld_nostrb");
    store_chk(0, BASE + 64'h17, 64'h5500_0000_0000_0000, 8'h80, 1'b0, "st_lowbits");
    load_chk (0, BASE + 64'h11, 64'h5522_3344_AAAA_AAAA, 1'b0, "ld_lowbits");

    store_chk(0, BASE,            64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, "st_w0");
    store_chk(0, BASE + 64'h1FF8, 64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0, "st_last");
    load_chk (0, BASE + 64'h1FF8, 64'hFEDC_BA98_7654_3210, 1'b0, "ld_last");
    load_chk (0, 64'h7FFF_FFF8,   64'd0, 1'b1, "ld_below");
    load_chk (0, BASE + 64'h2000, 64'd0, 1'b1, "ld_above");
    store_chk(0, BASE + 64'h2000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 1'b1, "st_above");
    store_chk(0, 64'h7FFF_FFF8,   64'hBAD1_BAD1_BAD1_BAD1, 8'hFF, 1'b1, "st_below");
    load_chk (0, BASE,            64'h0123_4567_89AB_CDEF, 1'b0, "keep_w0");
    load_chk (0, BASE + 64'h1FF8, 64'hFEDC_BA98_7654_3210, 1'b0, "keep_last");
    load_chk (0, BASE + 64'h10,   64'h5522_3344_AAAA_AAAA, 1'b0, "keep_w2");

    // Backpressure: hold the response while a competing store is offered.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, BASE + 64'h10, 64'd0, 8'h00);
    wait_valid(0, lat);
    check("bp_lat", 64'(lat), 64'd2);
    req_wen[0]   = 1'b1;
    req_addr[0]  = BASE + 64'h10;
    req_wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_wstrb[0] = 8'hFF;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(rsp_valid[0]), 64'd1);
      check("bp_data", rsp_rdata[0], 64'h5522_3344_AAAA_AAAA);
      check("bp_req_ready", 64'(req_ready[0]), 64'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", 64'(rsp_valid[0]), 64'd0);
    check("bp_done_ready", 64'(req_ready[0]), 64'd1);
    load_chk(0, BASE + 64'h10, 64'h5522_3344_AAAA_AAAA, 1'b0, "bp_nowrite");

    // Reset right after accept drops the response; committed stores survive.
    for (int d = 0; d < 3; d++) begin
      v = 64'hC0DE_0000_0000_0000 | 64'(d);
      w = 64'h5EED_0000_0000_0000 | 64'(d);
      store_chk(d, BASE + 64'h40, v, 8'hFF, 1'b0, $sformatf("rw%0d_st", d));
      rsp_ready[d] = 1'b0;
      issue(d, 1'b0, BASE + 64'h40, 64'd0, 8'h00);
      rst_n[d] = 1'b0;
      #1;
      check($sformatf("rw%0d_rst_valid", d), 64'(rsp_valid[d]), 64'd0);
      check($sformatf("rw%0d_rst_ready", d), 64'(req_ready[d]), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[d] = 1'b1;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (rsp_valid[d] || !req_ready[d]) bad++;
      end
      check($sformatf("rw%0d_quiet", d), 64'(bad), 64'd0);

      issue(d, 1'b1, BASE + 64'h48, w, 8'hFF);
      rst_n[d] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[d] = 1'b1;
      load_chk(d, BASE + 64'h48, w, 1'b0, $sformatf("rw%0d_commit", d));
      load_chk(d, BASE + 64'h40, v, 1'b0, $sformatf("rw%0d_ld", d));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
